// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and sprite artwork for the sprite animator.
//   anim_mode_e   - animation sequencing mode (matches the 2-bit mode input)
//   pix_t         - palette index of one texel
//   SPRITE_FRAMES - NUM_FRAMES bitmaps; SPRITE_FRAMES[f][y][x] is one texel.
// The artwork is generated at elaboration time from a closed-form pattern
// so every frame, row and column holds distinguishable data.
package sprite_pkg;

    localparam int ROM_SPR_W  = 32;
    localparam int ROM_SPR_H  = 32;
    localparam int ROM_FRAMES = 4;
    localparam int ROM_PIX_W  = 3;

    typedef enum logic [1:0] {
        LOOP     = 2'b00,
        PINGPONG = 2'b01,
        ONESHOT  = 2'b10,
        FREEZE   = 2'b11
    } anim_mode_e;

    typedef logic [ROM_PIX_W-1:0] pix_t;

    typedef pix_t   [ROM_SPR_W-1:0]  row_t;
    typedef row_t   [ROM_SPR_H-1:0]  frame_t;
    typedef frame_t [ROM_FRAMES-1:0] rom_t;

    // Pattern mixes the high column/row bits into the low index bits so
    // that a wrong tx/ty bit or a wrong frame select changes the texel.
    function automatic rom_t gen_frames();
        rom_t r;
        for (int f = 0; f < ROM_FRAMES; f++) begin
            for (int y = 0; y < ROM_SPR_H; y++) begin
                for (int x = 0; x < ROM_SPR_W; x++) begin
                    r[f][y][x] = pix_t'(((x ^ (x >> 3)) + 3 * y + (y >> 3) + 5 * f)
                                        % (1 << ROM_PIX_W));
                end
            end
        end
        return r;
    endfunction

    localparam rom_t SPRITE_FRAMES = gen_frames();

endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: combinational texel lookup into the packaged artwork.
//   frame - animation frame number
//   ty    - texel row
//   tx    - texel column (already mirrored by the caller)
//   texel - palette index at {frame, ty, tx}
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int FI_W = 2,
    parameter int TX_W = 5,
    parameter int TY_W = 5
) (
    input  logic [FI_W-1:0] frame,
    input  logic [TY_W-1:0] ty,
    input  logic [TX_W-1:0] tx,
    output pix_t            texel
);

    assign texel = SPRITE_FRAMES[frame][ty][tx];

endmodule

// File: rtl/sprite_animator.sv
// sprite_animator: animated sprite overlay for a raster video pipeline.
//   frame_tick/restart/mode/speed - animation sequencer controls
//   mirror, sprite_x/y            - sprite placement and horizontal flip
//   hpos/vpos                     - current raster coordinate
//   pixel/pixel_hit               - palette index and hit flag, two cycles
//                                   after the matching hpos/vpos
//   frame_idx/done                - sequencer state (done = one-shot finished)
// The sprite dimensions and palette width must match the artwork held in
// sprite_pkg; the defaults are taken from there.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPR_W       = ROM_SPR_W,
    parameter int SPR_H       = ROM_SPR_H,
    parameter int NUM_FRAMES  = ROM_FRAMES,
    parameter int PIX_W       = ROM_PIX_W,
    parameter int COORD_W     = 10,
    parameter int SCALE_LOG2  = 0,
    parameter int HOLD_W      = 4,
    parameter int TRANSPARENT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                restart,
    input  logic [1:0]          mode,
    input  logic [HOLD_W-1:0]   speed,
    input  logic                mirror,
    input  logic [COORD_W-1:0]  sprite_x,
    input  logic [COORD_W-1:0]  sprite_y,
    input  logic [COORD_W-1:0]  hpos,
    input  logic [COORD_W-1:0]  vpos,
    output logic [PIX_W-1:0]    pixel,
    output logic                pixel_hit,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx,
    output logic                done
);

    localparam int FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int TX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int TY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [FI_W-1:0]  LAST_IDX = FI_W'(NUM_FRAMES - 1);
    localparam logic [PIX_W-1:0] TRANSP   = PIX_W'(TRANSPARENT);

    // ---------------- animation sequencer ----------------
    logic [FI_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              back_q, back_d;    // 1 = ping-pong moving toward frame 0
    logic              done_q, done_d;
    logic [HOLD_W-1:0] speed_eff;
    logic [HOLD_W:0]   hold_inc;
    logic              advance;

    always_comb begin
        idx_d     = idx_q;
        hold_d    = hold_q;
        back_d    = back_q;
        done_d    = done_q;
        speed_eff = (speed == '0) ? HOLD_W'(1) : speed;
        // One extra bit so a hold left above a newly lowered speed still
        // compares correctly and advances on this tick.
        hold_inc  = {1'b0, hold_q} + (HOLD_W + 1)'(1);
        advance   = hold_inc >= {1'b0, speed_eff};

        if (restart) begin
            idx_d  = '0;
            hold_d = '0;
            back_d = 1'b0;
            done_d = 1'b0;
        end else if (frame_tick) begin
            if (!advance) begin
                hold_d = hold_inc[HOLD_W-1:0];
            end else begin
                hold_d = '0;
                case (anim_mode_e'(mode))
                    LOOP: begin
                        back_d = 1'b0;
                        idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + FI_W'(1);
                    end
                    PINGPONG: begin
                        if (NUM_FRAMES > 1) begin
                            if (!back_q) begin
                                if (idx_q == LAST_IDX) begin
                                    back_d = 1'b1;
                                    idx_d  = LAST_IDX - FI_W'(1);
                                end else begin
                                    idx_d = idx_q + FI_W'(1);
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    back_d = 1'b0;
                                    idx_d  = FI_W'(1);
                                end else begin
                                    idx_d = idx_q - FI_W'(1);
                                end
                            end
                        end
                    end
                    ONESHOT: begin
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + FI_W'(1);
                        end
                        if (idx_d == LAST_IDX) begin
                            done_d = 1'b1;
                        end
                    end
                    default: ; // FREEZE: frame and direction held
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            hold_q <= '0;
            back_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            hold_q <= hold_d;
            back_q <= back_d;
            done_q <= done_d;
        end
    end

    assign frame_idx = idx_q;
    assign done      = done_q;

    // ---------------- pixel pipeline ----------------
    logic [COORD_W:0]   rel_x, rel_y;     // sign bit flags "left of / above"
    logic [COORD_W-1:0] tx_full, ty_full;
    logic [TX_W-1:0]    s1_tx_q, s1_tx_d;
    logic [TY_W-1:0]    s1_ty_q, s1_ty_d;
    logic [FI_W-1:0]    s1_frame_q, s1_frame_d;
    logic               s1_in_q, s1_in_d;
    logic [PIX_W-1:0]   pixel_q, pixel_d;
    logic               hit_q, hit_d;
    pix_t               rom_texel;

    always_comb begin
        rel_x   = {1'b0, hpos} - {1'b0, sprite_x};
        rel_y   = {1'b0, vpos} - {1'b0, sprite_y};
        tx_full = rel_x[COORD_W-1:0] >> SCALE_LOG2;
        ty_full = rel_y[COORD_W-1:0] >> SCALE_LOG2;
        s1_in_d = !rel_x[COORD_W] && !rel_y[COORD_W]
                  && (tx_full < COORD_W'(SPR_W)) && (ty_full < COORD_W'(SPR_H));
        s1_tx_d = mirror ? (TX_W'(SPR_W - 1) - tx_full[TX_W-1:0]) : tx_full[TX_W-1:0];
        s1_ty_d = ty_full[TY_W-1:0];
        // Frame captured alongside the coordinates so the fetch in stage 2
        // uses one consistent frame even if a tick lands in between.
        s1_frame_d = idx_q;
        pixel_d = s1_in_q ? PIX_W'(rom_texel) : TRANSP;
        hit_d   = s1_in_q;
    end

    sprite_rom #(
        .FI_W (FI_W),
        .TX_W (TX_W),
        .TY_W (TY_W)
    ) u_rom (
        .frame (s1_frame_q),
        .ty    (s1_ty_q),
        .tx    (s1_tx_q),
        .texel (rom_texel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_q    <= 1'b0;
            s1_tx_q    <= '0;
            s1_ty_q    <= '0;
            s1_frame_q <= '0;
            pixel_q    <= TRANSP;
            hit_q      <= 1'b0;
        end else begin
            s1_in_q    <= s1_in_d;
            s1_tx_q    <= s1_tx_d;
            s1_ty_q    <= s1_ty_d;
            s1_frame_q <= s1_frame_d;
            pixel_q    <= pixel_d;
            hit_q      <= hit_d;
        end
    end

    assign pixel     = pixel_q;
    assign pixel_hit = hit_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator (SCALE_LOG2 = 1, other parameters default).
// Directed sequences from the sequencer and pixel rules, then randomized
// traffic compared every cycle against a reference model.
module tb_sprite_animator;

    localparam int N     = 4;
    localparam int SW    = 32;
    localparam int SH    = 32;
    localparam int SCALE = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick, restart, mirror;
    logic [1:0] mode;
    logic [3:0] speed;
    logic [9:0] sprite_x, sprite_y, hpos, vpos;
    logic [2:0] pixel;
    logic       pixel_hit;
    logic [1:0] frame_idx;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    // model state (value after the most recent clock edge)
    int m_idx, m_dir, m_hold;
    bit m_done;
    logic [2:0] exp_q[$];
    logic       exp_hit_q[$];

    sprite_animator #(.SCALE_LOG2(SCALE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .restart    (restart),
        .mode       (mode),
        .speed      (speed),
        .mirror     (mirror),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .hpos       (hpos),
        .vpos       (vpos),
        .pixel      (pixel),
        .pixel_hit  (pixel_hit),
        .frame_idx  (frame_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Artwork as drawn: palette index of texel (x,y) in frame f.
    function automatic int tex(input int f, input int y, input int x);
        return ((x ^ (x >> 3)) + 3 * y + (y >> 3) + 5 * f) % 8;
    endfunction

    function automatic void model_reset();
        m_idx  = 0;
        m_dir  = 1;
        m_hold = 0;
        m_done = 0;
        exp_q.delete();
        exp_hit_q.delete();
        // stage-2 and stage-1 are both cleared by reset
        exp_q.push_back(3'd0); exp_hit_q.push_back(1'b0);
        exp_q.push_back(3'd0); exp_hit_q.push_back(1'b0);
    endfunction

    function automatic void model_edge(input bit tick, input bit rs);
        int eff, nxt;
        if (rs) begin
            m_idx = 0; m_dir = 1; m_hold = 0; m_done = 0;
        end else if (tick) begin
            eff = (speed == 0) ? 1 : int'(speed);
            if (m_hold + 1 < eff) begin
                m_hold++;
            end else begin
                m_hold = 0;
                case (mode)
                    2'd0: begin m_dir = 1; m_idx = (m_idx + 1) % N; end
                    2'd1: begin
                        nxt = m_idx + m_dir;
                        if (nxt < 0 || nxt >= N) begin
                            m_dir = -m_dir;
                            nxt = m_idx + m_dir;
                        end
                        m_idx = nxt;
                    end
                    2'd2: begin
                        if (m_idx < N - 1) m_idx++;
                        if (m_idx == N - 1) m_done = 1;
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic void model_pixel(output logic [2:0] p, output logic h);
        int rx, ry, tx, ty;
        rx = int'(hpos) - int'(sprite_x);
        ry = int'(vpos) - int'(sprite_y);
        tx = rx / (1 << SCALE);
        ty = ry / (1 << SCALE);
        h  = (rx >= 0) && (ry >= 0) && (tx < SW) && (ty < SH);
        if (mirror) tx = SW - 1 - tx;
        p  = h ? 3'(tex(m_idx, ty, tx)) : 3'd0;
    endfunction

    // Called at a falling edge: check outputs, apply controls, advance one cycle.
    task automatic step(input bit tick, input bit rs);
        logic [2:0] ep;
        logic       eh;
        ep = exp_q.pop_front();
        eh = exp_hit_q.pop_front();
        check("pixel", pixel, ep);
        check("pixel_hit", pixel_hit, eh);
        check("frame_idx", frame_idx, m_idx);
        check("done", done, m_done);
        frame_tick = tick;
        restart    = rs;
        model_pixel(ep, eh);
        exp_q.push_back(ep);
        exp_hit_q.push_back(eh);
        model_edge(tick, rs);
        @(negedge clk);
        frame_tick = 1'b0;
        restart    = 1'b0;
    endtask

    task automatic place(input int sx, input int sy, input int hx, input int vy, input bit mir);
        sprite_x = 10'(sx); sprite_y = 10'(sy);
        hpos = 10'(hx); vpos = 10'(vy); mirror = mir;
    endtask

    task automatic pix_probe(input string tag, input int sx, input int sy, input int hx,
                             input int vy, input bit mir, input int ep, input bit eh);
        place(sx, sy, hx, vy, mir);
        step(0, 0);
        step(0, 0);
        check({tag, "_pix"}, pixel, ep);
        check({tag, "_hit"}, pixel_hit, eh);
    endtask

    int loop_exp[10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
    int pp_exp[8]    = '{1, 2, 3, 2, 1, 0, 1, 2};
    int os_exp[5]    = '{1, 2, 3, 3, 3};
    int os_done[5]   = '{0, 0, 1, 1, 1};

    initial begin
        rst_n = 1'b0;
        frame_tick = 0; restart = 0; mode = 2'd0; speed = 4'd2;
        place(0, 0, 500, 500, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // loop, speed 2
        for (int i = 0; i < 10; i++) begin
            step(1, 0);
            check("loop_seq", frame_idx, loop_exp[i]);
        end

        // ping-pong, speed 1
        mode = 2'd1; speed = 4'd1;
        step(0, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            check("pingpong_seq", frame_idx, pp_exp[i]);
        end

        // one-shot, speed 1, then restart colliding with a tick
        mode = 2'd2;
        step(0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            check("oneshot_seq", frame_idx, os_exp[i]);
            check("oneshot_done", done, os_done[i]);
        end
        step(1, 1);
        check("restart_idx", frame_idx, 0);
        check("restart_done", done, 0);

        // pixel mapping: frame 0 now, one-shot idle
        pix_probe("inside", 100, 50, 103, 52, 0, tex(0, 1, 1), 1);
        pix_probe("left", 100, 50, 99, 52, 0, 0, 0);
        pix_probe("right", 100, 50, 164, 52, 0, 0, 0);
        pix_probe("last_col", 100, 50, 163, 113, 0, tex(0, 31, 31), 1);
        pix_probe("mirror", 0, 0, 0, 0, 1, tex(0, 0, SW - 1), 1);
        pix_probe("wrap", 1000, 50, 10, 52, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int offx, offy;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) speed = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                sprite_x = 10'($urandom_range(0, 1023));
                sprite_y = 10'($urandom_range(0, 1023));
            end
            mirror = 1'($urandom_range(0, 1));
            offx = int'($urandom_range(0, 74)) - 4;
            offy = int'($urandom_range(0, 74)) - 4;
            hpos = 10'((int'(sprite_x) + offx) & 1023);
            vpos = 10'((int'(sprite_y) + offy) & 1023);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
        end

        // asynchronous reset mid-line at frame 2
        mode = 2'd0; speed = 4'd1;
        place(100, 50, 103, 52, 0);
        step(0, 1);
        step(1, 0);
        step(1, 0);
        check("pre_rst_idx", frame_idx, 2);
        check("pre_rst_hit", pixel_hit, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pix", pixel, 0);
        check("async_rst_hit", pixel_hit, 0);
        check("async_rst_idx", frame_idx, 0);
        check("async_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 0);
        step(0, 0);
        check("post_rst_pix", pixel, tex(0, 1, 1));
        check("post_rst_hit", pixel_hit, 1);
        for (int i = 0; i < 20; i++) step(i % 3 == 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
